// File: rtl/pixel_coordinate_generator_pkg.sv
// Shared payload types and Q16.16 fixed-point helpers for the rasterizer front end.
package pixel_coordinate_generator_pkg;

    localparam int unsigned FIXED_W = 32;
    localparam int unsigned FRAC_W  = 16;
    localparam int unsigned COORD_W = 16;

    typedef logic signed [FIXED_W-1:0] fixed_t;
    typedef logic [COORD_W-1:0]        coord_t;

    typedef struct packed {
        fixed_t x;
        fixed_t y;
        fixed_t z;
    } vertex_t;

    typedef struct packed {
        vertex_t v0;
        vertex_t v1;
        vertex_t v2;
        fixed_t  area_inv;
    } attributed_triangle_t;

    typedef struct packed {
        logic last;
    } triangle_metadata_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } pixel_coordinate_t;

    typedef struct packed {
        logic last;
    } pixel_metadata_t;

    // Signed fixed multiply; fractional bits below the LSB are truncated.
    function automatic fixed_t mul(input fixed_t a, input fixed_t b);
        logic signed [2*FIXED_W-1:0] p;
        p = (2*FIXED_W)'(a) * (2*FIXED_W)'(b);
        return FIXED_W'(p >>> FRAC_W);
    endfunction

endpackage

// File: rtl/pixel_coordinate_generator.sv
// Bounding-box traversal: latches a triangle, clamps its box to the viewport and streams pixels.
// Optional build macro PIXEL_COORDINATE_GENERATOR_SERPENTINE_EN selects boustrophedon row order.
module pixel_coordinate_generator
    import pixel_coordinate_generator_pkg::*;
#(
    parameter int unsigned VIEWPORT_WIDTH  = 1,
    parameter int unsigned VIEWPORT_HEIGHT = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    output logic                 attributed_triangle_s_ready,
    input  logic                 attributed_triangle_s_valid,
    input  attributed_triangle_t attributed_triangle_s_data,
    input  triangle_metadata_t   attributed_triangle_s_metadata,
    input  logic                 attributed_triangle_m_ready,
    output logic                 attributed_triangle_m_valid,
    output attributed_triangle_t attributed_triangle_m_data,
    output triangle_metadata_t   attributed_triangle_m_metadata,
    input  logic                 pixel_coordinate_m_ready,
    output logic                 pixel_coordinate_m_valid,
    output pixel_coordinate_t    pixel_coordinate_m_data,
    output pixel_metadata_t      pixel_coordinate_m_metadata
);

    localparam int unsigned X_HI = VIEWPORT_WIDTH - 1;
    localparam int unsigned Y_HI = VIEWPORT_HEIGHT - 1;
    localparam fixed_t X_SCALE   = FIXED_W'(X_HI << FRAC_W);
    localparam fixed_t Y_SCALE   = FIXED_W'(Y_HI << FRAC_W);
    localparam fixed_t FRAC_MASK = FIXED_W'((1 << FRAC_W) - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SCAN} state_t;

    state_t               r_state, w_state;
    logic                 r_s_ready, w_s_ready;
    attributed_triangle_t r_tri, w_tri;
    triangle_metadata_t   r_tri_meta, w_tri_meta;
    logic                 r_tri_valid, w_tri_valid;
    logic                 r_pix_valid, w_pix_valid;
    pixel_coordinate_t    r_pix, w_pix;
    logic                 r_pix_last, w_pix_last;
    coord_t               r_x_min, w_x_min;
    coord_t               r_x_max, w_x_max;
    coord_t               r_y_max, w_y_max;
    coord_t               w_x_end;
    coord_t               w_x_lo, w_x_hi, w_y_lo, w_y_hi;
    coord_t               w_x_hi_raw, w_y_hi_raw;
    logic                 w_advance;
`ifdef PIXEL_COORDINATE_GENERATOR_SERPENTINE_EN
    logic                 r_odd, w_odd;
`endif

    function automatic fixed_t min3(input fixed_t a, input fixed_t b, input fixed_t c);
        fixed_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic fixed_t max3(input fixed_t a, input fixed_t b, input fixed_t c);
        fixed_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic fixed_t floor_int(input fixed_t v);
        return v >>> FRAC_W;
    endfunction

    function automatic fixed_t ceil_int(input fixed_t v);
        return (v + FRAC_MASK) >>> FRAC_W;
    endfunction

    function automatic coord_t clamp(input fixed_t v, input int unsigned hi);
        fixed_t hi_f;
        hi_f = FIXED_W'(hi);
        if (v < 0)    return '0;
        if (v > hi_f) return COORD_W'(hi);
        return COORD_W'(v);
    endfunction

    // Box bounds from the latched triangle; evaluated during SETUP.
    always_comb begin
        w_x_lo     = clamp(floor_int(mul(min3(r_tri.v0.x, r_tri.v1.x, r_tri.v2.x), X_SCALE)), X_HI);
        w_x_hi_raw = clamp(ceil_int(mul(max3(r_tri.v0.x, r_tri.v1.x, r_tri.v2.x), X_SCALE)), X_HI);
        w_y_lo     = clamp(floor_int(mul(min3(r_tri.v0.y, r_tri.v1.y, r_tri.v2.y), Y_SCALE)), Y_HI);
        w_y_hi_raw = clamp(ceil_int(mul(max3(r_tri.v0.y, r_tri.v1.y, r_tri.v2.y), Y_SCALE)), Y_HI);
        w_x_hi     = (w_x_lo > w_x_hi_raw) ? w_x_lo : w_x_hi_raw;
        w_y_hi     = (w_y_lo > w_y_hi_raw) ? w_y_lo : w_y_hi_raw;
    end

`ifdef PIXEL_COORDINATE_GENERATOR_SERPENTINE_EN
    assign w_x_end = r_odd ? r_x_min : r_x_max;
`else
    assign w_x_end = r_x_max;
`endif

    assign w_advance = r_pix_valid && pixel_coordinate_m_ready
                    && (!r_tri_valid || attributed_triangle_m_ready);

    always_comb begin
        w_state     = r_state;
        w_s_ready   = r_s_ready;
        w_tri       = r_tri;
        w_tri_meta  = r_tri_meta;
        w_tri_valid = r_tri_valid;
        w_pix_valid = r_pix_valid;
        w_pix       = r_pix;
        w_pix_last  = r_pix_last;
        w_x_min     = r_x_min;
        w_x_max     = r_x_max;
        w_y_max     = r_y_max;
`ifdef PIXEL_COORDINATE_GENERATOR_SERPENTINE_EN
        w_odd       = r_odd;
`endif
        case (r_state)
            S_IDLE: begin
                w_s_ready = 1'b1;
                if (attributed_triangle_s_valid && r_s_ready) begin
                    w_tri      = attributed_triangle_s_data;
                    w_tri_meta = attributed_triangle_s_metadata;
                    w_s_ready  = 1'b0;
                    w_state    = S_SETUP;
                end
            end
            S_SETUP: begin
                w_x_min     = w_x_lo;
                w_x_max     = w_x_hi;
                w_y_max     = w_y_hi;
                w_pix.x     = w_x_lo;
                w_pix.y     = w_y_lo;
                w_pix_last  = (w_x_lo == w_x_hi) && (w_y_lo == w_y_hi);
                w_pix_valid = 1'b1;
                w_tri_valid = 1'b1;
`ifdef PIXEL_COORDINATE_GENERATOR_SERPENTINE_EN
                w_odd       = 1'b0;
`endif
                w_state     = S_SCAN;
            end
            S_SCAN: begin
                if (w_advance) begin
                    w_tri_valid = 1'b0;
                    if (r_pix_last) begin
                        w_pix_valid = 1'b0;
                        w_pix_last  = 1'b0;
                        w_s_ready   = 1'b1;
                        w_state     = S_IDLE;
                    end else if (r_pix.x == w_x_end) begin
                        w_pix.y = r_pix.y + COORD_W'(1);
`ifdef PIXEL_COORDINATE_GENERATOR_SERPENTINE_EN
                        // Row turn: x stays put and the direction flips.
                        w_odd      = !r_odd;
                        w_pix_last = (w_pix.y == r_y_max)
                                  && (r_pix.x == (r_odd ? r_x_max : r_x_min));
`else
                        w_pix.x    = r_x_min;
                        w_pix_last = (w_pix.y == r_y_max) && (r_x_min == r_x_max);
`endif
                    end else begin
`ifdef PIXEL_COORDINATE_GENERATOR_SERPENTINE_EN
                        w_pix.x = r_odd ? (r_pix.x - COORD_W'(1)) : (r_pix.x + COORD_W'(1));
`else
                        w_pix.x = r_pix.x + COORD_W'(1);
`endif
                        w_pix_last = (r_pix.y == r_y_max) && (w_pix.x == w_x_end);
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_s_ready   <= 1'b0;
            r_tri       <= '0;
            r_tri_meta  <= '0;
            r_tri_valid <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix       <= '0;
            r_pix_last  <= 1'b0;
            r_x_min     <= '0;
            r_x_max     <= '0;
            r_y_max     <= '0;
`ifdef PIXEL_COORDINATE_GENERATOR_SERPENTINE_EN
            r_odd       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state;
            r_s_ready   <= w_s_ready;
            r_tri       <= w_tri;
            r_tri_meta  <= w_tri_meta;
            r_tri_valid <= w_tri_valid;
            r_pix_valid <= w_pix_valid;
            r_pix       <= w_pix;
            r_pix_last  <= w_pix_last;
            r_x_min     <= w_x_min;
            r_x_max     <= w_x_max;
            r_y_max     <= w_y_max;
`ifdef PIXEL_COORDINATE_GENERATOR_SERPENTINE_EN
            r_odd       <= w_odd;
`endif
        end
    end

    assign attributed_triangle_s_ready    = r_s_ready;
    assign attributed_triangle_m_valid    = r_tri_valid;
    assign attributed_triangle_m_data     = r_tri;
    assign attributed_triangle_m_metadata = r_tri_meta;
    assign pixel_coordinate_m_valid       = r_pix_valid;
    assign pixel_coordinate_m_data        = r_pix;
    assign pixel_coordinate_m_metadata.last = r_pix_last;

endmodule

// File: tb/tb_pixel_coordinate_generator.sv
// Directed bench for pixel_coordinate_generator on a 5x5 viewport.
module tb_pixel_coordinate_generator;
    import pixel_coordinate_generator_pkg::*;

    localparam fixed_t F_0    = 32'sh0000_0000;
    localparam fixed_t F_025  = 32'sh0000_4000;
    localparam fixed_t F_05   = 32'sh0000_8000;
    localparam fixed_t F_075  = 32'sh0000_C000;
    localparam fixed_t F_1    = 32'sh0001_0000;
    localparam fixed_t F_N025 = -32'sh0000_4000;
    localparam fixed_t F_N05  = -32'sh0000_8000;
    localparam fixed_t F_N075 = -32'sh0000_C000;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 s_ready;
    logic                 s_valid;
    attributed_triangle_t s_data;
    triangle_metadata_t   s_meta;
    logic                 tri_ready;
    logic                 tri_valid;
    attributed_triangle_t tri_data;
    triangle_metadata_t   tri_meta;
    logic                 pix_ready;
    logic                 pix_valid;
    pixel_coordinate_t    pix_data;
    pixel_metadata_t      pix_meta;

    int n_vec = 0;
    int n_err = 0;
    int exp_x [16];
    int exp_y [16];

    pixel_coordinate_generator #(
        .VIEWPORT_WIDTH (5),
        .VIEWPORT_HEIGHT(5)
    ) dut (
        .clk                           (clk),
        .rstn                          (rstn),
        .attributed_triangle_s_ready   (s_ready),
        .attributed_triangle_s_valid   (s_valid),
        .attributed_triangle_s_data    (s_data),
        .attributed_triangle_s_metadata(s_meta),
        .attributed_triangle_m_ready   (tri_ready),
        .attributed_triangle_m_valid   (tri_valid),
        .attributed_triangle_m_data    (tri_data),
        .attributed_triangle_m_metadata(tri_meta),
        .pixel_coordinate_m_ready      (pix_ready),
        .pixel_coordinate_m_valid      (pix_valid),
        .pixel_coordinate_m_data       (pix_data),
        .pixel_coordinate_m_metadata   (pix_meta)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic attributed_triangle_t make_tri(input fixed_t x0, input fixed_t y0,
                                                      input fixed_t x1, input fixed_t y1,
                                                      input fixed_t x2, input fixed_t y2);
        attributed_triangle_t t;
        t.v0.x = x0; t.v0.y = y0; t.v0.z = 32'sh0000_1111;
        t.v1.x = x1; t.v1.y = y1; t.v1.z = 32'sh0000_2222;
        t.v2.x = x2; t.v2.y = y2; t.v2.z = 32'sh0000_3333;
        t.area_inv = 32'sh0008_0000;
        return t;
    endfunction

    // Box x,y in [1,3]
    task automatic load_inscribed();
        exp_x = '{1,2,3, 1,2,3, 1,2,3, 0,0,0,0,0,0,0};
        exp_y = '{1,1,1, 2,2,2, 3,3,3, 0,0,0,0,0,0,0};
`ifdef PIXEL_COORDINATE_GENERATOR_SERPENTINE_EN
        exp_x = '{1,2,3, 3,2,1, 1,2,3, 0,0,0,0,0,0,0};
`endif
    endtask

    // Off-screen left: x box 0..0, y 2..4
    task automatic load_offscreen();
        exp_x = '{0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0,0};
        exp_y = '{2,3,4, 0,0,0,0,0,0,0,0,0,0,0,0,0};
    endtask

    // Small corner box x,y in [0,1]
    task automatic load_small();
        exp_x = '{0,1,0,1, 0,0,0,0,0,0,0,0,0,0,0,0};
        exp_y = '{0,0,1,1, 0,0,0,0,0,0,0,0,0,0,0,0};
`ifdef PIXEL_COORDINATE_GENERATOR_SERPENTINE_EN
        exp_x = '{0,1,1,0, 0,0,0,0,0,0,0,0,0,0,0,0};
`endif
    endtask

    // Hand over a triangle (s_ready must already be high) and check the full pixel stream.
    task automatic run_tri(input attributed_triangle_t t, input logic tlast, input int n,
                           input int stall_idx, input int stall_len, input logic stall_tri,
                           input string nm);
        logic [35:0] got, want;
        n_vec++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_accept_ready: got %b expected 1", nm, s_ready);
        end
        s_data  = t;
        s_meta.last = tlast;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        s_data  = '1;
        s_meta.last = ~tlast;
        n_vec++;
        if ({pix_valid, tri_valid, s_ready} !== 3'b000) begin
            n_err++;
            $display("FAIL %s_setup_cycle: got pv/tv/rdy %b expected 000", nm, {pix_valid, tri_valid, s_ready});
        end
        step();
        for (int i = 0; i < n; i++) begin
            want = {1'b1, 1'b1, 1'(i == 0), 16'(exp_x[i]), 16'(exp_y[i]), 1'(i == n - 1)};
            if (i == stall_idx) begin
                if (stall_tri) tri_ready = 1'b0;
                else           pix_ready = 1'b0;
                for (int k = 0; k < stall_len; k++) begin
                    got = {pix_valid, ~s_ready, tri_valid, pix_data.x, pix_data.y, pix_meta.last};
                    n_vec++;
                    if (got !== want) begin
                        n_err++;
                        $display("FAIL %s_stall_pix%0d_cyc%0d: got %h expected %h", nm, i, k, got, want);
                    end
                    step();
                end
                tri_ready = 1'b1;
                pix_ready = 1'b1;
            end
            got = {pix_valid, ~s_ready, tri_valid, pix_data.x, pix_data.y, pix_meta.last};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL %s_pix%0d: got %h expected %h", nm, i, got, want);
            end
            n_vec++;
            if ({tri_data, tri_meta.last} !== {t, tlast}) begin
                n_err++;
                $display("FAIL %s_tri_hold%0d: got last %b expected %b", nm, i, tri_meta.last, tlast);
            end
            step();
        end
        n_vec++;
        if ({pix_valid, tri_valid, s_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL %s_after_last: got pv/tv/rdy %b expected 001", nm, {pix_valid, tri_valid, s_ready});
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        s_meta = '0;
        tri_ready = 1'b1;
        pix_ready = 1'b1;
        step();
        n_vec++;
        if ({s_ready, tri_valid, pix_valid, pix_data, pix_meta.last, tri_data, tri_meta.last} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy %b tv %b pv %b pix %h", s_ready, tri_valid, pix_valid, pix_data);
        end
        rstn = 1'b1;
        step();
        n_vec++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b expected 1", s_ready);
        end
    endtask

    task automatic test_inscribed();
        load_inscribed();
        run_tri(make_tri(F_025, F_025, F_075, F_025, F_025, F_075), 1'b0, 9, -1, 0, 1'b0, "inscribed");
    endtask

    task automatic test_offscreen();
        load_offscreen();
        run_tri(make_tri(F_N05, F_05, F_N025, F_1, F_N075, F_075), 1'b0, 3, -1, 0, 1'b0, "offscreen");
    endtask

    task automatic test_pixel_stall();
        load_inscribed();
        run_tri(make_tri(F_025, F_025, F_075, F_025, F_025, F_075), 1'b0, 9, 4, 3, 1'b0, "pix_stall");
    endtask

    // Triangle port not ready on the first pixel: nothing may move.
    task automatic test_first_ready_split();
        load_inscribed();
        run_tri(make_tri(F_025, F_025, F_075, F_025, F_025, F_075), 1'b0, 9, 0, 2, 1'b1, "tri_stall");
    endtask

    task automatic test_back_to_back();
        load_offscreen();
        run_tri(make_tri(F_N05, F_05, F_N025, F_1, F_N075, F_075), 1'b0, 3, -1, 0, 1'b0, "b2b_first");
        load_small();
        run_tri(make_tri(F_0, F_0, F_025, F_0, F_0, F_025), 1'b1, 4, 2, 1, 1'b0, "b2b_second");
    endtask

    task automatic test_reset_mid_scan();
        s_data  = make_tri(F_025, F_025, F_075, F_025, F_025, F_075);
        s_meta.last = 1'b1;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        repeat (4) step();
        n_vec++;
        if ({pix_valid, pix_data.x, pix_data.y} !== {1'b1, 16'd1, 16'd2}) begin
            n_err++;
            $display("FAIL midreset_pixel4: got v%b (%0d,%0d) expected v1 (1,2)", pix_valid, pix_data.x, pix_data.y);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_vec++;
        if ({pix_valid, tri_valid, s_ready, tri_meta.last} !== 4'b0000) begin
            n_err++;
            $display("FAIL midreset_async_clear: got %b expected 0000", {pix_valid, tri_valid, s_ready, tri_meta.last});
        end
        step();
        rstn = 1'b1;
        step();
        load_inscribed();
        run_tri(make_tri(F_025, F_025, F_075, F_025, F_025, F_075), 1'b0, 9, -1, 0, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_inscribed();
        test_offscreen();
        test_pixel_stall();
        test_first_ready_split();
        test_back_to_back();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
